// File: rtl/fetch_unit_if.sv
// Byte-wide instruction-memory port between the fetch stage (master) and memory (slave).
// Request/address held by the master until ack; err is only meaningful alongside ack.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        imem_ack;
    logic        imem_err;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ack, imem_err);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack, imem_err);
endinterface

// File: rtl/fetch_unit.sv
// Y86 byte-serial fetch: reads 1-6 bytes per instruction over imem, decodes, then holds until d_ready_i.
// Latency k+1 cycles for k bytes with zero-wait acks; f_busy_o stalls the PC register while not IDLE.
module fetch_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         f_pc_i,
    input  logic                f_start_i,
    input  logic                d_ready_i,
    fetch_unit_if.master        imem,
    output logic [3:0]          f_icode_o,
    output logic [3:0]          f_ifun_o,
    output logic [3:0]          f_rA_o,
    output logic [3:0]          f_rB_o,
    output logic [31:0]         f_valC_o,
    output logic [31:0]         f_valP_o,
    output logic [2:0]          f_stat_o,
    output logic                f_valid_o,
    output logic                f_busy_o
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [8:0] TMO      = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  len_q, len_d;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [31:0] valc_q, valc_d;
    logic [31:0] valp_q, valp_d;
    logic [2:0]  stat_q, stat_d;
    logic        valid_q, valid_d;

    logic        has_reg;
    logic [1:0]  pos;
    logic        timeout_hit;
    logic        go_adr;
    logic [3:0]  byte_ic;

    function automatic logic [2:0] insn_len(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: return 3'd2;
            4'h3, 4'h4, 4'h5:       return 3'd6;
            4'h7, 4'h8:             return 3'd5;
            default:                return 3'd1;
        endcase
    endfunction

    assign has_reg     = (len_q == 3'd2) || (len_q == 3'd6);
    // valC byte position: bytes after the optional register byte, LSB first
    assign pos         = 2'(idx_q - (has_reg ? 3'd2 : 3'd1));
    assign timeout_hit = (TIMEOUT != 0) && (({1'b0, wait_q} + 9'd1) == TMO);
    assign byte_ic     = imem.imem_rdata[7:4];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        len_d   = len_q;
        wait_d  = wait_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        stat_d  = stat_q;
        valid_d = valid_q;
        go_adr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (f_start_i) begin
                    state_d = FETCH;
                    pc_d    = f_pc_i;
                    idx_d   = 3'd0;
                    len_d   = 3'd0;
                    wait_d  = 8'd0;
                    icode_d = 4'h0;
                    ifun_d  = 4'h0;
                    ra_d    = REG_NONE;
                    rb_d    = REG_NONE;
                    valc_d  = 32'd0;
                    valp_d  = 32'd0;
                    stat_d  = STAT_AOK;
                end
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    wait_d = 8'd0;
                    idx_d  = idx_q + 3'd1;
                    if (imem.imem_err) begin
                        go_adr = 1'b1;
                    end else if (idx_q == 3'd0) begin
                        icode_d = byte_ic;
                        ifun_d  = imem.imem_rdata[3:0];
                        len_d   = insn_len(byte_ic);
                        valp_d  = pc_q + 32'd1;
                        if (byte_ic == 4'h0) begin
                            stat_d  = STAT_HLT;
                            state_d = HOLD;
                            valid_d = 1'b1;
                        end else if (byte_ic > 4'hB) begin
                            stat_d  = STAT_INS;
                            state_d = HOLD;
                            valid_d = 1'b1;
                        end else if (insn_len(byte_ic) == 3'd1) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                        end
                    end else begin
                        if (has_reg && (idx_q == 3'd1)) begin
                            ra_d = imem.imem_rdata[7:4];
                            rb_d = imem.imem_rdata[3:0];
                        end else begin
                            valc_d[{pos, 3'b000} +: 8] = imem.imem_rdata;
                        end
                        if ((idx_q + 3'd1) == len_q) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                            valp_d  = pc_q + 32'(len_q);
                        end
                    end
                end else if (timeout_hit) begin
                    go_adr = 1'b1;
                end else begin
                    wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
                end

                // Bad address: present a NOP so the pipeline can drain, restart PC = pc
                if (go_adr) begin
                    icode_d = 4'h1;
                    ifun_d  = 4'h0;
                    ra_d    = REG_NONE;
                    rb_d    = REG_NONE;
                    valc_d  = 32'd0;
                    valp_d  = pc_q;
                    stat_d  = STAT_ADR;
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (d_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= 32'd0;
            idx_q   <= 3'd0;
            len_q   <= 3'd0;
            wait_q  <= 8'd0;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= REG_NONE;
            rb_q    <= REG_NONE;
            valc_q  <= 32'd0;
            valp_q  <= 32'd0;
            stat_q  <= STAT_AOK;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            wait_q  <= wait_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            stat_q  <= stat_d;
            valid_q <= valid_d;
        end
    end

    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q + {29'd0, idx_q};
    assign f_icode_o      = icode_q;
    assign f_ifun_o       = ifun_q;
    assign f_rA_o         = ra_q;
    assign f_rB_o         = rb_q;
    assign f_valC_o       = valc_q;
    assign f_valP_o       = valp_q;
    assign f_stat_o       = stat_q;
    assign f_valid_o      = valid_q;
    assign f_busy_o       = (state_q != IDLE);
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Byte-serial instruction fetch stage for the Y86 pipeline.
- Sits directly downstream of the predicted-PC register. Takes the selected fetch PC, reads the instruction bytes one at a time over a req/ack instruction-memory port, and decodes the fields.
- Produces icode, ifun, rA, rB, valC, valP and stat for the D pipeline register.
- f_busy_o feeds the predicted-PC register's stall input.

Parameters:
- TIMEOUT, 16, cycles to wait for imem_ack_i per byte before flagging ADR; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- f_pc_i  in  32  fetch PC, sampled with f_start_i
- f_start_i  in  1  begin fetch; honoured only in IDLE
- d_ready_i  in  1  downstream accepts the current outputs
- imem_req_o  out  1  byte read request
- imem_addr_o  out  32  byte address
- imem_rdata_i  in  8  read byte, valid with ack
- imem_ack_i  in  1  read complete
- imem_err_i  in  1  address error, qualified by ack
- f_icode_o  out  4  instruction code
- f_ifun_o  out  4  function code
- f_rA_o  out  4  register A (F = none)
- f_rB_o  out  4  register B (F = none)
- f_valC_o  out  32  constant word, little-endian
- f_valP_o  out  32  PC of the next sequential instruction
- f_stat_o  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- f_valid_o  out  1  outputs valid, held until accepted
- f_busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (rst low at a clock edge):
  - state=IDLE; counters cleared.
  - Every output is 0 except f_rA_o=f_rB_o=4'hF and f_stat_o=AOK.
  - Acks arriving while rst is low are ignored.
  - Reset mid-fetch aborts the fetch; imem_req_o is low the cycle after.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - On f_start_i: latch pc=f_pc_i, set len=0 and byte index=0, go to FETCH.
  - f_start_i is ignored in FETCH and HOLD.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc+index (mod 2^32, so 0xFFFFFFFF wraps to 0).
  - Request and address stay stable until ack.
  - On ack, capture the byte and increment the index. The next request may be issued the following cycle.
- Byte map:
  - byte0 = {icode, ifun}.
  - Where present, byte1 = {rA, rB}.
  - The following 4 bytes form valC, LSB first.
- Lengths by icode:
  - 0 HALT, 1 NOP, 9 RET: 1 byte.
  - 2 RRMOVL, 6 OPL, A PUSHL, B POPL: 2 bytes.
  - 3 IRMOVL, 4 RMMOVL, 5 MRMOVL: 6 bytes.
  - 7 JXX, 8 CALL: 5 bytes (no register byte; valC occupies bytes 1-4).
- Field defaults: fields not fetched read rA=rB=F and valC=0.
- Normal completion: after the last byte's ack, go to HOLD with f_valid_o=1 and valP=pc+len (mod 2^32).
- Status and early termination (all stop fetching immediately):
  - icode 0 gives HLT.
  - icode > B gives INS, with valP=pc+1.
  - ack with imem_err_i gives ADR, icode=1 (NOP), valP=pc.
  - Per-byte wait counter reaching TIMEOUT gives ADR, same values as an error; a late ack is ignored.
- HOLD:
  - Outputs stay frozen while d_ready_i=0.
  - On d_ready_i=1: f_valid_o drops next cycle and the state goes to IDLE.
  - f_start_i is sampled from the cycle after the return to IDLE.
- Latency: with start sampled at edge T and zero-wait acks, a k-byte instruction has imem_req_o high for cycles T+1..T+k and f_valid_o high from T+k+1.
- The wait counter is 8 bits, saturating, and clears on each ack.

Test Plan:
1. pc=0x100, bytes 30 F2 78 56 34 12, zero-wait acks -> f_valid_o at start+7; icode=3, rA=F, rB=2, valC=0x12345678, valP=0x106, stat=AOK.
2. pc=0xFFFFFFFE, JXX bytes 70 44 33 22 11 -> addresses FFFFFFFE, FFFFFFFF, 0, 1, 2; valC=0x11223344, valP=0x3.
3. byte0=0xC0 -> one request only; stat=INS, valP=pc+1, rA=rB=F. Byte0=0x00 -> stat=HLT, valP=pc+1.
4. irmovl with imem_err_i on byte 3 -> four requests, stat=ADR, icode=1, valP=pc. With TIMEOUT=16 and no ack -> ADR exactly 16 cycles after the request rises.
5. d_ready_i low for 5 cycles after valid -> outputs and f_busy_o held 5 cycles; a start pulse during HOLD is ignored.
6. rst low while waiting on byte 2 -> next cycle imem_req_o=0, f_valid_o=0, state IDLE; a subsequent ack produces no output change.
